// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin owner of the register-file write port.
// Ports: clk/rst (sync, active-high); req_valid/addr/data in, req_ready out
// (one-hot grant); wb_stall in; wb_addr/wb_data/wb_src/err_drop registered out.
module regfile_wb_arbiter #(
  parameter int NREGS    = 19,
  parameter int DSP_BASE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [14:0] req_addr,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  input  logic        wb_stall,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_src,
  output logic        err_drop
);

  localparam logic [1:0]  DSP_ID   = 2'd2;
  localparam logic [31:0] NREGS_U  = 32'(NREGS);
  localparam logic [31:0] DSPB_U   = 32'(DSP_BASE);

  logic [1:0]  last_grant_q, last_grant_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [1:0]  wb_src_q, wb_src_d;
  logic        err_drop_q, err_drop_d;

  logic [4:0]  addr0, addr1, addr2;
  logic [31:0] data0, data1, data2;
  logic [1:0]  p0, p1, p2;
  logic [2:0]  grant;
  logic        hs;
  logic [1:0]  sel;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic [31:0] sel_addr_w;
  logic        out_of_range;
  logic        dsp_owned;
  logic        illegal;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    addr0 = req_addr[4:0];
    addr1 = req_addr[9:5];
    addr2 = req_addr[14:10];
    data0 = req_data[31:0];
    data1 = req_data[63:32];
    data2 = req_data[95:64];
  end

  // Priority rotates: the requester after the last winner is searched first.
  always_comb begin
    p0    = nxt(last_grant_q);
    p1    = nxt(p0);
    p2    = nxt(p1);
    grant = 3'b000;
    if (!rst && !wb_stall) begin
      if (req_valid[p0])
        grant[p0] = 1'b1;
      else if (req_valid[p1])
        grant[p1] = 1'b1;
      else if (req_valid[p2])
        grant[p2] = 1'b1;
    end
  end

  always_comb begin
    sel      = 2'd0;
    sel_addr = addr0;
    sel_data = data0;
    unique case (1'b1)
      grant[0]: begin
        sel      = 2'd0;
        sel_addr = addr0;
        sel_data = data0;
      end
      grant[1]: begin
        sel      = 2'd1;
        sel_addr = addr1;
        sel_data = data1;
      end
      grant[2]: begin
        sel      = 2'd2;
        sel_addr = addr2;
        sel_data = data2;
      end
      default: begin
        sel      = 2'd0;
        sel_addr = addr0;
        sel_data = data0;
      end
    endcase
  end

  // Illegal destinations are still consumed, but the write is dropped.
  always_comb begin
    sel_addr_w   = {27'd0, sel_addr};
    out_of_range = sel_addr_w >= NREGS_U;
    dsp_owned    = (sel_addr_w >= DSPB_U) && (sel != DSP_ID);
    illegal      = out_of_range || dsp_owned;
  end

  always_comb begin
    hs           = |grant;
    last_grant_d = hs ? sel : last_grant_q;
    wb_addr_d    = (hs && !illegal) ? sel_addr : 5'd0;
    wb_data_d    = hs ? sel_data : wb_data_q;
    wb_src_d     = hs ? sel : wb_src_q;
    err_drop_d   = hs && illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 2'd2;
      wb_addr_q    <= 5'd0;
      wb_data_q    <= 32'd0;
      wb_src_q     <= 2'd0;
      err_drop_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      wb_src_q     <= wb_src_d;
      err_drop_q   <= err_drop_d;
    end
  end

  assign req_ready = grant;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign wb_src    = wb_src_q;
  assign err_drop  = err_drop_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREGS, default 19, number of implemented architectural registers (0..NREGS-1).
REQ-002 Parameter DSP_BASE, default 16, lowest register index reserved for the DSP requester; DSP_BASE..NREGS-1 are DSP-owned.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  3  per-requester write request; bit 0 ALU, bit 1 LSU, bit 2 DSP.
REQ-006 Port req_addr  input  15  three 5-bit destination indices, requester i at [5i+4:5i].
REQ-007 Port req_data  input  96  three 32-bit write values, requester i at [32i+31:32i].
REQ-008 Port req_ready  output  3  one-hot grant; bit i high means requester i's request is consumed this cycle.
REQ-009 Port wb_stall  input  1  write port unavailable; no grant while high.
REQ-010 Port wb_addr  output  5  registered write-port index to the register file; 0 means no write.
REQ-011 Port wb_data  output  32  registered write-port data.
REQ-012 Port wb_src  output  2  index of the requester that produced the current wb_addr/wb_data (0..2).
REQ-013 Port err_drop  output  1  one-cycle pulse: a granted request was discarded (illegal destination).

Function
REQ-014 The block SHALL be the only driver of the register file write port and SHALL grant at most one requester per cycle (req_ready one-hot or zero).
REQ-015 req_ready is combinational from req_valid, wb_stall and the round-robin pointer; req_ready[i] SHALL never be high while req_valid[i] is low.
REQ-016 When wb_stall is high, req_ready SHALL be 0 and wb_addr SHALL be 0 in the following cycle; requests SHALL be held by requesters (valid stays high, payload stable) until granted.
REQ-017 Arbitration SHALL be round-robin: search order starts at (last_grant+1) mod 3; last_grant updates only on a grant.
REQ-018 A handshake (req_valid[i] and req_ready[i] high at a rising edge) SHALL produce wb_addr/wb_data/wb_src in the next cycle: latency exactly 1 cycle; register file updates at the end of that cycle.
REQ-019 In any cycle with no handshake, wb_addr SHALL be 0 next cycle; wb_data and wb_src hold their previous values.
REQ-020 Destination 0 from any requester SHALL be granted and produce wb_addr=0; err_drop SHALL stay low (legal no-op).
REQ-021 Destination >= NREGS SHALL be granted, produce wb_addr=0, and pulse err_drop for one cycle aligned with the would-be writeback cycle.
REQ-022 Destination in DSP_BASE..NREGS-1 from requester 0 or 1 SHALL be granted, produce wb_addr=0, and pulse err_drop; same destination from requester 2 SHALL write normally.
REQ-023 Requester 2 MAY write any register 1..NREGS-1.
REQ-024 Back-to-back grants SHALL be sustained: with all three valid and no stall, one write per cycle in order 0,1,2,0,...
REQ-025 Two requesters targeting the same register SHALL be serialized in grant order; last granted value wins in the register file.
REQ-026 A request whose valid drops before grant SHALL leave no effect.

Reset
REQ-027 While rst is high at a rising edge: wb_addr=0, wb_data=0, wb_src=0, err_drop=0, last_grant=2 (so requester 0 has first priority); req_ready SHALL be 0 during any cycle rst is high.
REQ-028 A grant pending in the output register when rst asserts SHALL be discarded (wb_addr forced 0 next cycle); no write reaches the register file.
REQ-029 First cycle after rst deasserts SHALL arbitrate normally with requester 0 highest priority.

Verification
REQ-030 After reset, valid=3'b111, addrs 5/6/17, data A/B/C, no stall -> ready 001,010,100 on consecutive cycles; wb_addr 5,6,17 one cycle later; requester 1 addr 6 wins over 0? no, order 0,1,2; wb_src 0,1,2.
REQ-031 Requester 0 writes addr 17 -> granted, wb_addr=0 next cycle, err_drop pulse 1 cycle; requester 2 addr 17 data 0xDEADBEEF -> wb_addr=17, wb_data=0xDEADBEEF, err_drop=0.
REQ-032 Requester 1 addr 25 -> wb_addr=0, err_drop pulse; requester 0 addr 0 -> wb_addr=0, err_drop=0.
REQ-033 wb_stall high 3 cycles with valid=3'b011 -> req_ready=0, wb_addr=0 throughout; stall low -> grant 0 then 1, payload unchanged.
REQ-034 Grant requester 1 addr 9, assert rst next edge -> wb_addr stays 0, all outputs at reset values; after release, valid=3'b110 -> requester 1 granted first.
REQ-035 Requesters 0 and 1 both target addr 4 with data 1 and 2 -> wb_addr=4 twice, data 1 then 2; register 4 ends at 2.
